dcache_resp: RTL
================

# dcache_resp

Data-side responder at the CPU load/store port. It terminates the CPU's dcache request bus (address, write data, read request, write select) and returns read data after a programmable latency, holding the CPU with a stall signal until completion. It sits where the data cache attaches to the CPU core. It is used as the functional stand-in for the data memory behind the CPU in system-level benches, and as the on-chip scratch data RAM in small builds.

## Interface
Parameters:
- AW, 10: word-address width; memory holds 2^AW 32-bit words.
- LATENCY, 2: cycles from request presentation to `dcache_valid_o`; legal range 1..15.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- dcache_waddr_i  in  32  byte address of the request; bits [1:0] are ignored.
- dcache_wdata_i  in  32  write data.
- dcache_wstrb_i  in  4  byte enables for writes; bit i enables byte lane [8i+7:8i].
- dcache_rreq_i  in  1  read request.
- dcache_wsel_i  in  1  write request.
- dcache_data_o  out  32  read data, or the merged word for a write; valid while `dcache_valid_o` is high.
- dcache_valid_o  out  1  one-cycle completion pulse.
- dcache_stall_o  out  1  CPU must hold its request and stall while high.
- dcache_err_o  out  1  out-of-range flag; asserted only together with `dcache_valid_o`.

## Operation
- Request present: `req = dcache_rreq_i | dcache_wsel_i`. If both are high, the request is a write. The read is ignored.
- FSM states:
  - IDLE: when `req` is high, capture the request at the edge and go to BUSY (or RESP if LATENCY==1), with `cnt = LATENCY-1`.
  - BUSY: decrement `cnt`; go to RESP when `cnt` reaches 1.
  - RESP: drive `valid=1`; go to IDLE unconditionally.
- Access at the capture edge:
  - Word index = `addr[AW+1:2]`.
  - Read: the indexed word is registered into the data register.
  - Write: `merged = (old & ~mask) | (wdata & mask)`, where mask is expanded from `wstrb`. The merged word is written to the array and also loaded into the data register.
- Out of range: `addr[31:AW+2] != 0`. Writes are dropped. The data register loads 32'h0. `dcache_err_o` is set for the RESP cycle.
- `dcache_stall_o = req & ~dcache_valid_o`. It is combinational from `req`.
- The CPU holds the request unchanged through the RESP cycle. The responder ignores the bus in BUSY and RESP.
- `dcache_data_o` holds its last value outside RESP. Checkers must only sample it while `dcache_valid_o` is high.
- Reset values: state IDLE, `cnt=0`, `dcache_valid_o=0`, `dcache_err_o=0`, `dcache_data_o=32'h0`, `dcache_stall_o=req`.
- The memory array has no reset; its contents survive reset.
- Reset asserted mid-operation: the transaction is abandoned. No valid pulse is issued. A write already performed at the capture edge stays in memory.

## Timing
- Request first presented in cycle 0: capture at the end of cycle 0; `dcache_valid_o` high in cycle LATENCY.
- `dcache_stall_o` is high in cycles 0..LATENCY-1 and low in cycle LATENCY.
- Back-to-back throughput: one request per LATENCY+1 cycles. The next request is sampled in IDLE at cycle LATENCY+1.
- Read-after-write to the same word in the next request returns the new data. There is no hazard because the write occurs at capture.
- `cnt` is 4 bits wide and never wraps below 1 in BUSY.

## Structure
- Package `dcache_pkg`: FSM state enum (IDLE, BUSY, RESP), `LAT_MAX=15`, and strobe-to-mask function `wstrb_to_mask`.
- Sub-module `dmem_array`: 2^AW x 32 storage with byte-enable write and synchronous read, same port.
- `dcache_resp` holds the FSM, latency counter, range check, and output registers.

## Test plan
- Reset: hold `rst=0` with `dcache_rreq_i=1` -> `valid=0`, `err=0`, `data_o=0`, `stall=1`. Release -> read completes normally LATENCY cycles later.
- Full write: LATENCY=2, write 0x0000_0010 / 0xDEADBEEF / wstrb 4'hF at cycle 0 -> `stall` high in cycles 0-1, `valid` high in cycle 2 with `data_o=0xDEADBEEF`. The following read of 0x10 returns 0xDEADBEEF.
- Partial write: wstrb 4'b0011, wdata 0x0000_1234 to 0x10 -> `data_o=0xDEAD1234`. The subsequent read returns 0xDEAD1234. Address 0x13 reads the same word.
- Out of range: AW=10, read 0x0000_1000 -> `valid` with `err=1`, `data_o=0`. A write to 0x0000_1000 leaves word 0 unchanged.
- Reset mid-BUSY: LATENCY=4, deassert `rst` at cycle 2 of a read -> no valid pulse. After release, a new read to 0x10 completes in exactly 4 cycles.
- Both requests high: `rreq=wsel=1`, wdata 0x55AA55AA to 0x20 -> treated as a write. `data_o=0x55AA55AA`, and a later read returns it.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and helpers for the dcache responder: FSM states, latency bound
// and byte-strobe expansion.
package dcache_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } state_t;

   localparam int unsigned LAT_MAX = 15;

   function automatic logic [31:0] wstrb_to_mask(input logic [3:0] wstrb);
      logic [31:0] mask;
      for (int i = 0; i < 4; i++) begin
         mask[8*i +: 8] = {8{wstrb[i]}};
      end
      return mask;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// 2^AW x 32 word store: byte-enable read-modify-write and registered read on a
// single port. Contents are not reset; only the read register is.
module dmem_array #(
   parameter int unsigned AW = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          we,
   input  logic [AW-1:0] idx,
   input  logic [31:0]   wdata,
   input  logic [31:0]   mask,
   output logic [31:0]   rdata
);

   logic [31:0] mem [2**AW];
   logic [31:0] merged;

   assign merged = (mem[idx] & ~mask) | (wdata & mask);

   always_ff @(posedge clk) begin
      if (en && we) begin
         mem[idx] <= merged;
      end
   end

   // A write returns the merged word so the CPU sees what was stored.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata <= 32'h0;
      end else if (en) begin
         rdata <= we ? merged : mem[idx];
      end
   end

endmodule

// File: rtl/dcache_resp.sv
// CPU data-port responder: captures a load/store, performs it immediately, and
// returns data LATENCY cycles later while stalling the CPU.
module dcache_resp
   import dcache_pkg::*;
#(
   parameter int unsigned AW      = 10,
   parameter int unsigned LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] dcache_waddr_i,
   input  logic [31:0] dcache_wdata_i,
   input  logic [3:0]  dcache_wstrb_i,
   input  logic        dcache_rreq_i,
   input  logic        dcache_wsel_i,
   output logic [31:0] dcache_data_o,
   output logic        dcache_valid_o,
   output logic        dcache_stall_o,
   output logic        dcache_err_o
);

   localparam logic [3:0] CntInit = 4'(LATENCY - 1);

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic        valid_q;
   logic        err_q;
   logic        oob_q;
   logic        req;
   logic        oob;
   logic        capture;
   logic [31:0] rdata;
   logic        unused_addr_lsb;

   assign req             = dcache_rreq_i | dcache_wsel_i;
   assign oob             = |dcache_waddr_i[31:AW+2];
   assign capture         = (state_q == IDLE) & req;
   assign unused_addr_lsb = ^dcache_waddr_i[1:0];

   dmem_array #(
      .AW (AW)
   ) u_mem (
      .clk   (clk),
      .rst   (rst),
      .en    (capture & ~oob),
      .we    (dcache_wsel_i),
      .idx   (dcache_waddr_i[AW+1:2]),
      .wdata (dcache_wdata_i),
      .mask  (wstrb_to_mask(dcache_wstrb_i)),
      .rdata (rdata)
   );

   // Out-of-range accesses never touch the array, so their zero data is forced here.
   assign dcache_data_o  = oob_q ? 32'h0 : rdata;
   assign dcache_valid_o = valid_q;
   assign dcache_err_o   = err_q;
   assign dcache_stall_o = req & ~valid_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         oob_q   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (req) begin
                  oob_q <= oob;
                  cnt_q <= CntInit;
                  if (LATENCY == 1) begin
                     state_q <= RESP;
                     valid_q <= 1'b1;
                     err_q   <= oob;
                  end else begin
                     state_q <= BUSY;
                  end
               end
            end
            BUSY: begin
               if (cnt_q <= 4'd1) begin
                  state_q <= RESP;
                  valid_q <= 1'b1;
                  err_q   <= oob_q;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            RESP: begin
               state_q <= IDLE;
               valid_q <= 1'b0;
               err_q   <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
